// File: rtl/synth_harness_seq.sv
// Sequencer for one synthesis-harness wrapper pair: serial load, settle, capture, sample.
// Optional `SYNTH_SEQ_LFSR_EN` replaces the vec input with an internal 32-bit Galois LFSR source.
module synth_harness_seq #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] vec,
  input  logic             pin_out,
  output logic             pin_in,
  output logic             pin_valid,
  output logic             pin_capture,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic [15:0]      runs
);

  localparam int BW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
  localparam int SW = ($clog2(SETTLE + 1) < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_SETTLE,
    S_CAPTURE,
    S_SAMPLE
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [WIDTH-1:0] shreg_shifted;
  logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [SW-1:0]    settle_cnt_reg, settle_cnt_next;
  logic [WIDTH-1:0] load_vec;
  logic             accept;

  // Output registers lag the state by one cycle; sample_reg marks the cycle pin_out is valid.
  logic        pin_in_reg, pin_in_next;
  logic        pin_valid_reg, pin_valid_next;
  logic        pin_capture_reg, pin_capture_next;
  logic        busy_reg, busy_next;
  logic        sample_reg, sample_next;
  logic        done_reg, done_next;
  logic        result_reg, result_next;
  logic [15:0] runs_reg, runs_next;

  assign accept = (state_reg == S_IDLE) && start;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_msb
        assign shreg_shifted[gi] = 1'b0;
      end else begin : g_mid
        assign shreg_shifted[gi] = shreg_reg[gi+1];
      end
    end
  endgenerate

`ifdef SYNTH_SEQ_LFSR_EN
  logic [31:0] lfsr_reg, lfsr_next;
  logic        unused_vec;

  assign unused_vec = ^vec;
  assign load_vec   = lfsr_reg[WIDTH-1:0];
  assign lfsr_next  = accept ? ({1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? 32'h80200003 : 32'h0))
                             : lfsr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= 32'h00000001;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end
`else
  assign load_vec = vec;
`endif

  always_comb begin
    state_next      = state_reg;
    shreg_next      = shreg_reg;
    bit_cnt_next    = bit_cnt_reg;
    settle_cnt_next = settle_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          shreg_next   = load_vec;
          bit_cnt_next = '0;
          state_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_next   = shreg_shifted;
        bit_cnt_next = bit_cnt_reg + 1'b1;
        if (bit_cnt_reg == BIT_LAST) begin
          settle_cnt_next = '0;
          state_next      = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        settle_cnt_next = settle_cnt_reg + 1'b1;
        if (settle_cnt_reg == SETTLE_LAST) begin
          state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: state_next = S_SAMPLE;
      S_SAMPLE:  state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase

    pin_valid_next   = (state_reg == S_SHIFT);
    pin_in_next      = (state_reg == S_SHIFT) && shreg_reg[0];
    pin_capture_next = (state_reg == S_CAPTURE);
    busy_next        = (state_reg != S_IDLE);
    sample_next      = (state_reg == S_SAMPLE);
    done_next        = sample_reg;
    result_next      = sample_reg ? pin_out : result_reg;
    runs_next        = runs_reg + {15'd0, sample_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      shreg_reg       <= '0;
      bit_cnt_reg     <= '0;
      settle_cnt_reg  <= '0;
      pin_in_reg      <= 1'b0;
      pin_valid_reg   <= 1'b0;
      pin_capture_reg <= 1'b0;
      busy_reg        <= 1'b0;
      sample_reg      <= 1'b0;
      done_reg        <= 1'b0;
      result_reg      <= 1'b0;
      runs_reg        <= 16'd0;
    end else begin
      state_reg       <= state_next;
      shreg_reg       <= shreg_next;
      bit_cnt_reg     <= bit_cnt_next;
      settle_cnt_reg  <= settle_cnt_next;
      pin_in_reg      <= pin_in_next;
      pin_valid_reg   <= pin_valid_next;
      pin_capture_reg <= pin_capture_next;
      busy_reg        <= busy_next;
      sample_reg      <= sample_next;
      done_reg        <= done_next;
      result_reg      <= result_next;
      runs_reg        <= runs_next;
    end
  end

  assign pin_in      = pin_in_reg;
  assign pin_valid   = pin_valid_reg;
  assign pin_capture = pin_capture_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign result      = result_reg;
  assign runs        = runs_reg;

endmodule

// File: tb/tb_synth_harness_seq.sv
// Bench for synth_harness_seq: wrapper-pair environment, run-phase reference model, per-cycle compare.
module tb_synth_harness_seq;
  localparam int W = 8;
  localparam int S = 2;

`ifdef SYNTH_SEQ_LFSR_EN
  localparam logic [7:0] R1V = 8'h01, R2V = 8'h03, R3V = 8'h01;
  localparam logic       R1R = 1'b1,  R2R = 1'b0,  R3R = 1'b1;
`else
  localparam logic [7:0] R1V = 8'hA5, R2V = 8'h07, R3V = 8'h3C;
  localparam logic       R1R = 1'b0,  R2R = 1'b1,  R3R = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  vec = 8'h00;
  logic        pin_out;
  logic        pin_in, pin_valid, pin_capture, busy, done, result;
  logic [15:0] runs;

  logic [7:0] wr_reg = 8'h00;
  logic       pout_reg = 1'b0;
  assign pin_out = pout_reg;

  always #5 clk = ~clk;

  synth_harness_seq #(.WIDTH(W), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec(vec), .pin_out(pin_out),
    .pin_in(pin_in), .pin_valid(pin_valid), .pin_capture(pin_capture),
    .busy(busy), .done(done), .result(result), .runs(runs)
  );

  // Input wrapper shifts in at MSB; output wrapper captures parity of it.
  always @(posedge clk) begin
    if (pin_valid) wr_reg <= {pin_in, wr_reg[7:1]};
    if (pin_capture) pout_reg <= ^wr_reg;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit cmp_en = 0;

  // Model: m_p = cycles since the accepting edge of the active run.
  bit          m_active;
  int          m_p;
  logic [7:0]  m_vl;
  logic [15:0] m_runs;
  logic        m_result, m_done;
  logic [31:0] m_lfsr;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_active = 0; m_p = 0; m_vl = 8'h00; m_runs = 16'd0;
    m_result = 1'b0; m_done = 1'b0; m_lfsr = 32'h00000001;
  endfunction

  function automatic void model_step();
    bit fin;
    fin = m_active && (m_p == W + S + 2);
    m_done = fin;
    if (fin) begin
      m_runs++;
      m_result = ^m_vl;
    end
    if (fin || !m_active) begin
      if (start) begin
        m_active = 1;
        m_p = 0;
`ifdef SYNTH_SEQ_LFSR_EN
        m_vl = m_lfsr[7:0];
        m_lfsr = {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h80200003 : 32'h0);
`else
        m_vl = vec;
`endif
      end else begin
        m_active = 0;
      end
    end else begin
      m_p++;
    end
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      bit   v;
      logic exp_in;
      v = m_active && (m_p >= 1) && (m_p <= W);
      exp_in = 1'b0;
      if (v) exp_in = m_vl[m_p-1];
      chk("busy", busy, m_active && (m_p >= 1));
      chk("pin_valid", pin_valid, v);
      chk("pin_in", pin_in, exp_in);
      chk("pin_capture", pin_capture, m_active && (m_p == W + S + 1));
      chk("done", done, m_done);
      chk("result", result, m_result);
      chk("runs", runs, m_runs);
      if (done) $display("run complete: cycle %0d result %0b runs %0d", cyc, result, runs);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    cyc++;
    @(negedge clk);
  endtask

  logic [7:0] seq, cap_wr;
  int cap_k, done_k, nd_run;

  task automatic run_one(input logic [7:0] v, input bit noise);
    vec = v; start = 1'b1;
    cap_k = -1; done_k = -1; nd_run = 0; seq = 8'h00; cap_wr = 8'h00;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (noise && k >= 2 && k <= 12) begin
        start = 1'($urandom_range(0, 1));
        vec = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
      if (k <= W) seq[k-1] = pin_in;
      if (pin_capture) begin
        cap_k = k;
        cap_wr = wr_reg;
      end
      if (done) begin
        done_k = k;
        nd_run++;
      end
    end
    start = 1'b0;
  endtask

  int d_cyc[3];
  int nd;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    cmp_en = 1;
    repeat (3) tick();
    chk("rst_pin_in", pin_in, 0);
    chk("rst_pin_valid", pin_valid, 0);
    chk("rst_pin_capture", pin_capture, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_runs", runs, 0);
    rst_n = 1'b1;
    tick();

    run_one(8'hA5, 0);
    chk("r1_pin_in_seq", seq, R1V);
    chk("r1_wrapper", cap_wr, R1V);
    chk("r1_capture_cycle", cap_k, 11);
    chk("r1_done_cycle", done_k, 13);
    chk("r1_done_count", nd_run, 1);
    chk("r1_result", result, R1R);
    chk("r1_runs", runs, 1);

    run_one(8'h07, 1);
    chk("r2_wrapper", cap_wr, R2V);
    chk("r2_done_count", nd_run, 1);
    chk("r2_result", result, R2R);
    chk("r2_runs", runs, 2);

    // Reset in cycle 4 of a run.
    vec = 8'($urandom); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pin_valid", pin_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_runs", runs, 0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_one(8'h3C, 0);
    chk("r3_wrapper", cap_wr, R3V);
    chk("r3_result", result, R3R);
    chk("r3_runs", runs, 1);

    // Start held high for three runs.
    nd = 0;
    start = 1'b1; vec = 8'($urandom);
    for (int i = 0; i < 60 && nd < 3; i++) begin
      tick();
      vec = 8'($urandom);
      if (done) begin
        d_cyc[nd] = cyc;
        nd++;
        if (nd == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("held_done_count", nd, 3);
    if (nd == 3) begin
      chk("held_gap1", d_cyc[1] - d_cyc[0], 13);
      chk("held_gap2", d_cyc[2] - d_cyc[1], 13);
    end
    chk("held_runs", runs, 4);
    repeat (15) tick();
    chk("held_idle_busy", busy, 0);

    // Random traffic with occasional resets.
    repeat (500) begin
      start = ($urandom_range(0, 2) == 0);
      vec = 8'($urandom);
      if ($urandom_range(0, 120) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    repeat (20) tick();
    chk("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
